// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - command-driven sequencer for the register-file/ALU datapath (option: ALU_SEQ_CARRY_CHAIN_EN)

package alu_seq_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5
  } aluop_t;
endpackage

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 9
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic              Cmd_Kind,
  input  aluop_t            Cmd_Op,
  input  logic [ADDR_W-1:0] Cmd_Src1,
  input  logic [ADDR_W-1:0] Cmd_Src2,
  input  logic [ADDR_W-1:0] Cmd_Dst,
  input  logic [DATA_W-1:0] Cmd_Imm,
  input  logic              Cmd_Carry,
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [OUT_W-1:0]  Rsp_Data,
  output logic [ADDR_W-1:0] Read_Addr_1,
  output logic [ADDR_W-1:0] Read_Addr_2,
  output aluop_t            Opcode,
  output logic              Carry_In,
  input  logic [OUT_W-1:0]  ALU_Result,
  output logic [ADDR_W-1:0] Write_Addr,
  output logic              Write_enable,
  output logic [DATA_W-1:0] Write_data,
  output logic [15:0]       Op_Count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [OUT_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] read_addr_1_q, read_addr_1_d;
  logic [ADDR_W-1:0] read_addr_2_q, read_addr_2_d;
  aluop_t            opcode_q, opcode_d;
  logic              carry_in_q, carry_in_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic              write_enable_q, write_enable_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [15:0]       op_count_q, op_count_d;
  logic [ADDR_W-1:0] dst_q, dst_d;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic carry_q, carry_d;
  logic alu_carry_out;

  // Carry-out exists only when the ALU result is wider than a register word
  if (OUT_W > DATA_W) begin : g_carry_bit
    assign alu_carry_out = ALU_Result[DATA_W];
  end else begin : g_no_carry_bit
    assign alu_carry_out = 1'b0;
  end
`endif

  // Next-state and next-output computation for the command FSM
  always_comb begin
    state_d        = state_q;
    cmd_ready_d    = cmd_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    read_addr_1_d  = read_addr_1_q;
    read_addr_2_d  = read_addr_2_q;
    opcode_d       = opcode_q;
    carry_in_d     = carry_in_q;
    write_addr_d   = write_addr_q;
    write_enable_d = write_enable_q;
    write_data_d   = write_data_q;
    op_count_d     = op_count_q;
    dst_d          = dst_q;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    carry_d        = carry_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Ready rises one cycle after entering IDLE (including after reset)
        cmd_ready_d = 1'b1;
        if (Cmd_Valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          dst_d       = Cmd_Dst;
          if (Cmd_Kind) begin
            read_addr_1_d = Cmd_Src1;
            read_addr_2_d = Cmd_Src2;
            opcode_d      = Cmd_Op;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            carry_in_d    = Cmd_Carry | carry_q;
`else
            carry_in_d    = Cmd_Carry;
`endif
            state_d       = S_ISSUE;
          end else begin
            write_data_d   = Cmd_Imm;
            write_addr_d   = Cmd_Dst;
            rsp_data_d     = OUT_W'(Cmd_Imm);
            write_enable_d = 1'b1;
            state_d        = S_WB;
          end
        end
      end

      S_ISSUE: begin
        // Operands are read this cycle, so an in-place write in WB is safe
        rsp_data_d     = ALU_Result;
        write_data_d   = ALU_Result[DATA_W-1:0];
        write_addr_d   = dst_q;
        write_enable_d = 1'b1;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
        carry_d        = alu_carry_out;
`endif
        state_d        = S_WB;
      end

      S_WB: begin
        write_enable_d = 1'b0;
        rsp_valid_d    = 1'b1;
        state_d        = S_RESP;
      end

      S_RESP: begin
        if (rsp_valid_q && Rsp_Ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q        <= S_IDLE;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      read_addr_1_q  <= '0;
      read_addr_2_q  <= '0;
      opcode_q       <= ALU_ADD;
      carry_in_q     <= 1'b0;
      write_addr_q   <= '0;
      write_enable_q <= 1'b0;
      write_data_q   <= '0;
      op_count_q     <= '0;
      dst_q          <= '0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      carry_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      read_addr_1_q  <= read_addr_1_d;
      read_addr_2_q  <= read_addr_2_d;
      opcode_q       <= opcode_d;
      carry_in_q     <= carry_in_d;
      write_addr_q   <= write_addr_d;
      write_enable_q <= write_enable_d;
      write_data_q   <= write_data_d;
      op_count_q     <= op_count_d;
      dst_q          <= dst_d;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      carry_q        <= carry_d;
`endif
    end
  end

  assign Cmd_Ready    = cmd_ready_q;
  assign Rsp_Valid    = rsp_valid_q;
  assign Rsp_Data     = rsp_data_q;
  assign Read_Addr_1  = read_addr_1_q;
  assign Read_Addr_2  = read_addr_2_q;
  assign Opcode       = opcode_q;
  assign Carry_In     = carry_in_q;
  assign Write_Addr   = write_addr_q;
  assign Write_enable = write_enable_q;
  assign Write_data   = write_data_q;
  assign Op_Count     = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int OUT_W  = 9;

  logic              Clock = 1'b0;
  logic              Reset_n;
  logic              Cmd_Valid;
  logic              Cmd_Ready;
  logic              Cmd_Kind;
  aluop_t            Cmd_Op;
  logic [ADDR_W-1:0] Cmd_Src1, Cmd_Src2, Cmd_Dst;
  logic [DATA_W-1:0] Cmd_Imm;
  logic              Cmd_Carry;
  logic              Rsp_Valid;
  logic              Rsp_Ready;
  logic [OUT_W-1:0]  Rsp_Data;
  logic [ADDR_W-1:0] Read_Addr_1, Read_Addr_2;
  aluop_t            Opcode;
  logic              Carry_In;
  logic [OUT_W-1:0]  ALU_Result;
  logic [ADDR_W-1:0] Write_Addr;
  logic              Write_enable;
  logic [DATA_W-1:0] Write_data;
  logic [15:0]       Op_Count;

  alu_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Kind(Cmd_Kind), .Cmd_Op(Cmd_Op),
    .Cmd_Src1(Cmd_Src1), .Cmd_Src2(Cmd_Src2), .Cmd_Dst(Cmd_Dst), .Cmd_Imm(Cmd_Imm),
    .Cmd_Carry(Cmd_Carry), .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Data(Rsp_Data),
    .Read_Addr_1(Read_Addr_1), .Read_Addr_2(Read_Addr_2), .Opcode(Opcode), .Carry_In(Carry_In),
    .ALU_Result(ALU_Result), .Write_Addr(Write_Addr), .Write_enable(Write_enable),
    .Write_data(Write_data), .Op_Count(Op_Count)
  );

  always #5 Clock = ~Clock;

  // Register file and ALU environment
  logic [DATA_W-1:0] rf [16];
  logic              rf_clr;
  logic [DATA_W-1:0] alu_a, alu_b;

  always @(posedge Clock) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (Write_enable) begin
      rf[Write_Addr] <= Write_data;
    end
  end

  always_comb begin
    alu_a = rf[Read_Addr_1];
    alu_b = rf[Read_Addr_2];
    case (Opcode)
      ALU_ADD: ALU_Result = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, Carry_In};
      ALU_SUB: ALU_Result = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_AND: ALU_Result = {1'b0, alu_a & alu_b};
      ALU_OR:  ALU_Result = {1'b0, alu_a | alu_b};
      ALU_XOR: ALU_Result = {1'b0, alu_a ^ alu_b};
      default: ALU_Result = {1'b0, alu_a};
    endcase
  end

  typedef struct {
    logic              kind;
    aluop_t            op;
    logic [ADDR_W-1:0] s1, s2, dst;
    logic [DATA_W-1:0] imm;
    logic              cin;
    logic [DATA_W-1:0] exp_wd;
    logic [OUT_W-1:0]  exp_rsp;
  } vec_t;

  vec_t vecs[13];
  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;

  function automatic vec_t mk(input logic kind, input aluop_t op, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] dst, input logic [7:0] imm,
                              input logic cin, input logic [7:0] wd, input logic [8:0] rsp);
    vec_t v;
    v.kind = kind; v.op = op; v.s1 = s1; v.s2 = s2; v.dst = dst;
    v.imm = imm; v.cin = cin; v.exp_wd = wd; v.exp_rsp = rsp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_cmd(input vec_t v);
    Cmd_Valid = 1'b1; Cmd_Kind = v.kind; Cmd_Op = v.op;
    Cmd_Src1 = v.s1; Cmd_Src2 = v.s2; Cmd_Dst = v.dst;
    Cmd_Imm = v.imm; Cmd_Carry = v.cin;
  endtask

  // Wait (bounded) for Cmd_Ready, then let the accept edge pass
  task automatic accept_cmd(input string tag);
    int n;
    n = 0;
    while (!Cmd_Ready && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (!Cmd_Ready) chk({tag, "_ready_timeout"}, 0, 1);
    @(posedge Clock);
    @(negedge Clock);
    Cmd_Valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, we_n;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    string tag;
    tag = $sformatf("v%0d", idx);
    wa = '0; wd = '0; we_n = 0; cyc = 1;
    drive_cmd(v);
    accept_cmd(tag);
    while (!Rsp_Valid && cyc < 20) begin
      if (Write_enable) begin we_n++; wa = Write_Addr; wd = Write_data; end
      @(negedge Clock);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, v.kind ? 3 : 2);
    chk({tag, "_we_pulses"}, we_n, 1);
    chk({tag, "_write_addr"}, wa, v.dst);
    chk({tag, "_write_data"}, wd, v.exp_wd);
    chk({tag, "_rsp_data"}, Rsp_Data, v.exp_rsp);
    @(posedge Clock);
    @(negedge Clock);
    exp_count++;
    chk({tag, "_op_count"}, Op_Count, exp_count);
    chk({tag, "_rsp_valid_drop"}, Rsp_Valid, 0);
    chk({tag, "_cmd_ready_back"}, Cmd_Ready, 1);
    chk({tag, "_rf_commit"}, rf[v.dst], v.exp_wd);
  endtask

  initial begin
    vec_t bp, rs;
    Reset_n = 1'b0; rf_clr = 1'b1; Cmd_Valid = 1'b0; Cmd_Kind = 1'b0; Cmd_Op = ALU_ADD;
    Cmd_Src1 = '0; Cmd_Src2 = '0; Cmd_Dst = '0; Cmd_Imm = '0; Cmd_Carry = 1'b0; Rsp_Ready = 1'b1;

    vecs[0]  = mk(1'b0, ALU_ADD, 4'd0,  4'd0,  4'd1,  8'h5A, 1'b0, 8'h5A, 9'h05A);
    vecs[1]  = mk(1'b0, ALU_ADD, 4'd0,  4'd0,  4'd1,  8'hF0, 1'b0, 8'hF0, 9'h0F0);
    vecs[2]  = mk(1'b0, ALU_ADD, 4'd0,  4'd0,  4'd2,  8'h20, 1'b0, 8'h20, 9'h020);
    vecs[3]  = mk(1'b1, ALU_ADD, 4'd1,  4'd2,  4'd3,  8'h00, 1'b0, 8'h10, 9'h110);
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    vecs[4]  = mk(1'b1, ALU_ADD, 4'd2,  4'd2,  4'd4,  8'h00, 1'b0, 8'h41, 9'h041);
`else
    vecs[4]  = mk(1'b1, ALU_ADD, 4'd2,  4'd2,  4'd4,  8'h00, 1'b0, 8'h40, 9'h040);
`endif
    vecs[5]  = mk(1'b0, ALU_ADD, 4'd0,  4'd0,  4'd1,  8'h03, 1'b0, 8'h03, 9'h003);
    vecs[6]  = mk(1'b1, ALU_ADD, 4'd1,  4'd1,  4'd1,  8'h00, 1'b0, 8'h06, 9'h006);
    vecs[7]  = mk(1'b1, ALU_SUB, 4'd2,  4'd1,  4'd6,  8'h00, 1'b0, 8'h1A, 9'h01A);
    vecs[8]  = mk(1'b1, ALU_AND, 4'd2,  4'd1,  4'd7,  8'h00, 1'b0, 8'h00, 9'h000);
    vecs[9]  = mk(1'b1, ALU_XOR, 4'd2,  4'd1,  4'd8,  8'h00, 1'b0, 8'h26, 9'h026);
    vecs[10] = mk(1'b1, ALU_ADD, 4'd2,  4'd1,  4'd9,  8'h00, 1'b1, 8'h27, 9'h027);
    vecs[11] = mk(1'b0, ALU_ADD, 4'd0,  4'd0,  4'd15, 8'hFF, 1'b0, 8'hFF, 9'h0FF);
    vecs[12] = mk(1'b1, ALU_ADD, 4'd15, 4'd15, 4'd11, 8'h00, 1'b0, 8'hFE, 9'h1FE);

    // Reset state
    repeat (3) @(posedge Clock);
    rf_clr = 1'b0;
    @(negedge Clock);
    chk("rst_cmd_ready", Cmd_Ready, 0);
    chk("rst_rsp_valid", Rsp_Valid, 0);
    chk("rst_write_enable", Write_enable, 0);
    chk("rst_carry_in", Carry_In, 0);
    chk("rst_op_count", Op_Count, 0);
    chk("rst_rsp_data", Rsp_Data, 0);
    chk("rst_addrs", {Read_Addr_1, Read_Addr_2, Write_Addr, Write_data}, 0);
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rel_cmd_ready", Cmd_Ready, 1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Response backpressure: response held, new command ignored
    bp = mk(1'b0, ALU_ADD, 4'd0, 4'd0, 4'd12, 8'h77, 1'b0, 8'h77, 9'h077);
    Rsp_Ready = 1'b0;
    drive_cmd(bp);
    accept_cmd("bp");
    for (int n = 0; n < 20 && !Rsp_Valid; n++) @(negedge Clock);
    chk("bp_rsp_valid_seen", Rsp_Valid, 1);
    bp = mk(1'b0, ALU_ADD, 4'd0, 4'd0, 4'd13, 8'hEE, 1'b0, 8'h00, 9'h000);
    drive_cmd(bp);
    for (int n = 0; n < 5; n++) begin
      chk("bp_rsp_valid_hold", Rsp_Valid, 1);
      chk("bp_rsp_data_hold", Rsp_Data, 9'h077);
      chk("bp_cmd_ready_low", Cmd_Ready, 0);
      chk("bp_op_count_hold", Op_Count, exp_count);
      chk("bp_no_write", Write_enable, 0);
      @(negedge Clock);
    end
    Cmd_Valid = 1'b0;
    Rsp_Ready = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    exp_count++;
    chk("bp_op_count_after", Op_Count, exp_count);
    chk("bp_rsp_valid_drop", Rsp_Valid, 0);
    chk("bp_cmd_ready_back", Cmd_Ready, 1);
    repeat (2) @(negedge Clock);
    chk("bp_ignored_not_written", rf[13], 8'h00);
    chk("bp_rf12", rf[12], 8'h77);

    // Reset sampled during ISSUE
    rs = mk(1'b1, ALU_ADD, 4'd1, 4'd2, 4'd14, 8'h00, 1'b0, 8'h00, 9'h000);
    drive_cmd(rs);
    accept_cmd("rs");
    Reset_n = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b1;
    exp_count = 0;
    chk("rs_no_write", Write_enable, 0);
    chk("rs_rsp_valid", Rsp_Valid, 0);
    chk("rs_op_count", Op_Count, 0);
    chk("rs_cmd_ready_low", Cmd_Ready, 0);
    @(negedge Clock);
    chk("rs_cmd_ready_back", Cmd_Ready, 1);
    chk("rs_no_write2", Write_enable, 0);
    chk("rs_rsp_valid2", Rsp_Valid, 0);
    chk("rs_rf14", rf[14], 8'h00);
    rs = mk(1'b0, ALU_ADD, 4'd0, 4'd0, 4'd14, 8'h3C, 1'b0, 8'h3C, 9'h03C);
    run_vec(rs, 99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-driven initiator for the register-file/ALU datapath. It accepts one command at a time over a valid/ready handshake and drives the register file's read ports, ALU opcode and carry-in. It captures the ALU result, writes it back to the register file through the write port, and returns the result over a valid/ready response channel. It sits between a test driver or microcontroller front end and the existing register-file/ALU block, and owns every input of that block.

## Interface
- DATA_W, 8: register-file word width and ALU operand width.
- ADDR_W, REGFILE_ADDR_WIDTH: register address width.
- OUT_W, ALU_OUTPUT_WIDTH: ALU result width, at least DATA_W.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  synchronous active-low reset, sampled on the rising edge of Clock.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  sequencer can accept a command.
- Cmd_Kind  in  1  0 = LOAD (write Cmd_Imm to Cmd_Dst), 1 = EXEC (ALU op).
- Cmd_Op  in  aluop_t  ALU operation for EXEC.
- Cmd_Src1, Cmd_Src2, Cmd_Dst  in  ADDR_W each  operand and destination register addresses.
- Cmd_Imm  in  DATA_W  immediate for LOAD.
- Cmd_Carry  in  1  carry-in for EXEC; see Configuration.
- Rsp_Valid  out  1  response present.
- Rsp_Ready  in  1  consumer accepts the response.
- Rsp_Data  out  OUT_W  full ALU result (EXEC) or zero-extended immediate (LOAD).
- Read_Addr_1, Read_Addr_2  out  ADDR_W each  register-file read addresses.
- Opcode  out  aluop_t  ALU operation.
- Carry_In  out  1  ALU carry-in.
- ALU_Result  in  OUT_W  ALU output; combinational from the read ports and opcode.
- Write_Addr  out  ADDR_W  register-file write address.
- Write_enable  out  1  register-file write strobe.
- Write_data  out  DATA_W  register-file write data.
- Op_Count  out  16  count of completed commands; wraps modulo 2^16.

## Operation
- All outputs are registered.
- Reset values:
  - Cmd_Ready = 0, Rsp_Valid = 0, Write_enable = 0, Carry_In = 0.
  - All addresses, Opcode, Write_data, Rsp_Data and Op_Count = 0.
  - Carry flag = 0. State = IDLE.
- FSM states: IDLE, ISSUE, WB, RESP.
- IDLE:
  - Cmd_Ready = 1.
  - Accept on Cmd_Valid && Cmd_Ready. Latch Cmd_Dst, Cmd_Imm and Cmd_Kind, then drop Cmd_Ready.
  - EXEC: load Read_Addr_1 = Cmd_Src1, Read_Addr_2 = Cmd_Src2, Opcode = Cmd_Op, Carry_In per Configuration, then go to ISSUE.
  - LOAD: load Write_data = Cmd_Imm and Write_Addr = Cmd_Dst, set Rsp_Data = zero-extended Cmd_Imm, assert Write_enable, then go to WB.
- ISSUE:
  - Read ports and Opcode are stable for the whole cycle.
  - At the end of the cycle, capture ALU_Result into Rsp_Data.
  - Write_data = ALU_Result[DATA_W-1:0], Write_Addr = latched Dst, assert Write_enable.
  - Carry flag = ALU_Result[DATA_W] when OUT_W > DATA_W, else 0. Go to WB.
- WB:
  - Write_enable = 1 for exactly this cycle; the register file commits at the closing edge.
  - Then deassert Write_enable, assert Rsp_Valid and go to RESP.
- RESP:
  - Hold Rsp_Valid and Rsp_Data stable until Rsp_Ready.
  - On the edge with Rsp_Valid && Rsp_Ready: drop Rsp_Valid, increment Op_Count, assert Cmd_Ready, go to IDLE.
- Commands are strictly serialized. Src == Dst is legal: operands are read in ISSUE, before the write in WB.
- Cmd_Valid while Cmd_Ready = 0 is ignored. The command inputs only need to be stable in the accept cycle.
- LOAD does not change the carry flag.
- Read_Addr, Opcode and Carry_In keep their last values outside ISSUE.
- Reset mid-operation:
  - Any edge with Reset_n = 0 returns all state to reset values. The pending response is discarded.
  - If that edge falls in WB, the write strobe already presented completes at that edge. Write_enable is 0 from the next cycle.

## Timing
- Accept edge = edge 0.
- EXEC: ISSUE in cycle 1, Write_enable high in cycle 2, Rsp_Valid first high in cycle 3.
- LOAD: Write_enable high in cycle 1, Rsp_Valid first high in cycle 2.
- With Rsp_Ready held at 1: EXEC is 4 cycles/command, LOAD is 3 cycles/command.
- Cmd_Ready returns to 1 the cycle after the response handshake.
- After Reset_n rises, Cmd_Ready = 1 from the first cycle following the first edge with Reset_n = 1.

## Configuration
- ALU_SEQ_CARRY_CHAIN_EN defined: EXEC drives Carry_In = Cmd_Carry | carry flag, so a chained op with Cmd_Carry = 0 picks up the previous EXEC's carry-out.
- ALU_SEQ_CARRY_CHAIN_EN not defined: Carry_In = Cmd_Carry. The carry flag register is not implemented.

## Test plan
- Reset, then LOAD r1 = 8'h5A with Rsp_Ready = 1 -> one-cycle Write_enable with Write_Addr = 1, Write_data = 8'h5A; Rsp_Data = 8'h5A; Op_Count = 1.
- LOAD r1 = 8'hF0, LOAD r2 = 8'h20, EXEC add r3 = r1 + r2, Cmd_Carry = 0 -> Write_data = 8'h10, Rsp_Data carry bit = 1, Rsp_Valid high 3 cycles after the EXEC accept.
- Carry chain: previous step followed by EXEC add r4 = r2 + r2 with Cmd_Carry = 0 -> Write_data = 8'h41 with ALU_SEQ_CARRY_CHAIN_EN defined, 8'h40 without it.
- Response backpressure: Rsp_Ready held at 0 for 5 cycles -> Rsp_Valid and Rsp_Data stable, Cmd_Ready = 0, a new Cmd_Valid is ignored, Op_Count unchanged until the handshake.
- In-place EXEC add r1 = r1 + r1 with r1 = 8'h03 -> reads 8'h03 in ISSUE, writes 8'h06 to r1 in WB.
- Reset_n = 0 sampled during ISSUE -> no write strobe, Rsp_Valid stays 0, Op_Count = 0, Cmd_Ready = 1 one cycle after reset release.
